// File: rtl/star_scanner.sv
// Raster reader: walks the 160x120 image memory, reports each STAR_COL pixel and waits for ack.
// Optional STAR_COUNT_EN adds a saturating per-frame hit counter on starCount.
module star_scanner #(
  parameter int XSZ   = 8,
  parameter int YSZ   = 7,
  parameter int COLSZ = 3,
  parameter int XMAX  = 160,
  parameter int YMAX  = 120,
  parameter logic [COLSZ-1:0] STAR_COL = 3'b111
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             go,
  input  logic             ack,
  output logic [14:0]      rdAddr,
  output logic             rdEn,
  input  logic [COLSZ-1:0] rdData,
  output logic [XSZ-1:0]   xOut,
  output logic [YSZ-1:0]   yOut,
  output logic             starFound,
`ifdef STAR_COUNT_EN
  output logic [15:0]      starCount,
`endif
  output logic             scanDone
);

  typedef enum logic [1:0] {IDLE, SCAN, FOUND, DONE} state_t;

  localparam logic [XSZ-1:0] XLAST = XSZ'(XMAX - 1);
  localparam logic [YSZ-1:0] YLAST = YSZ'(YMAX - 1);

  state_t           r_state;
  state_t           w_next;
  logic [XSZ-1:0]   r_xc;
  logic [YSZ-1:0]   r_yc;
  logic             r_exh;
  logic             r_pv;
  logic [XSZ-1:0]   r_px;
  logic [YSZ-1:0]   r_py;
  logic [XSZ-1:0]   r_xout;
  logic [YSZ-1:0]   r_yout;

  logic             w_issue;
  logic             w_hit;
  logic             w_start;
  logic [XSZ-1:0]   w_bx;
  logic [YSZ-1:0]   w_by;
  logic             w_wrap;
  logic             w_end;
  logic [XSZ-1:0]   w_nx;
  logic [YSZ-1:0]   w_ny;
  logic [14:0]      w_y15;

  assign w_issue = (r_state == SCAN) && !r_exh;
  assign w_hit   = (r_state == SCAN) && r_pv && (rdData == STAR_COL);
  assign w_start = (r_state == IDLE) && go;

  // On a hit the counter restarts just after the hit pixel; the read issued alongside is dropped.
  assign w_bx   = w_hit ? r_px : r_xc;
  assign w_by   = w_hit ? r_py : r_yc;
  assign w_wrap = (w_bx == XLAST);
  assign w_end  = w_wrap && (w_by == YLAST);
  assign w_nx   = w_wrap ? '0 : w_bx + 1'b1;
  assign w_ny   = w_wrap ? w_by + 1'b1 : w_by;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (go) w_next = SCAN;
      SCAN: begin
        if (w_hit)      w_next = FOUND;
        else if (r_exh) w_next = DONE;
      end
      FOUND:   if (ack) w_next = r_exh ? DONE : SCAN;
      DONE:    if (!go) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_y15     = 15'(r_yc);
    rdAddr    = (w_y15 << 7) + (w_y15 << 5) + 15'(r_xc);
    rdEn      = w_issue;
    starFound = (r_state == FOUND);
    scanDone  = (r_state == DONE);
    xOut      = r_xout;
    yOut      = r_yout;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_xc   <= '0;
      r_yc   <= '0;
      r_exh  <= 1'b0;
      r_pv   <= 1'b0;
      r_px   <= '0;
      r_py   <= '0;
      r_xout <= '0;
      r_yout <= '0;
    end else begin
      r_pv <= w_issue && !w_hit;
      if (w_issue) begin
        r_px <= r_xc;
        r_py <= r_yc;
      end
      if (w_start) begin
        r_xc  <= '0;
        r_yc  <= '0;
        r_exh <= 1'b0;
      end else if (w_hit || w_issue) begin
        r_exh <= w_end;
        if (!w_end) begin
          r_xc <= w_nx;
          r_yc <= w_ny;
        end
      end
      if (w_hit) begin
        r_xout <= r_px;
        r_yout <= r_py;
      end
    end
  end

`ifdef STAR_COUNT_EN
  logic [15:0] r_count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (w_start) begin
      r_count <= '0;
    end else if (w_hit && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign starCount = r_count;
`endif

endmodule
